sb_drain_ctrl: RTL and testbench

- Sequences draining of store-buffer entries into the D-cache.
- Arbitrates the single D-cache port between pipeline loads and store-buffer drain writes.
- Sits between the store buffer (entry valid bits, pop) and the D-cache (req/ack write handshake).
- Handles fence drain-to-empty and pipeline stall generation.

---
 rtl/sb_drain_ctrl_pkg.sv | 9 +
 rtl/sb_prio_enc.sv | 15 +
 rtl/sb_drain_ctrl.sv | 61 ++++++
 tb/tb_sb_drain_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sb_drain_ctrl_pkg.sv
// sb_drain_ctrl_pkg: shared store-buffer constants and drain state encodings
package sb_drain_ctrl_pkg;
  localparam int STOREBUFFER_NUM_LINES = 4;
  typedef enum logic [1:0] {
    SBD_IDLE = 2'd0,
    SBD_REQ  = 2'd1,
    SBD_POP  = 2'd2
  } sbd_state_t;
endpackage

// File: rtl/sb_prio_enc.sv
// sb_prio_enc: lowest-set-bit encoder with an any-valid flag
module sb_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) idx = vec[i] ? W'(i) : idx;
    any = |vec;
  end
endmodule

// File: rtl/sb_drain_ctrl.sv
// sb_drain_ctrl: drains store-buffer entries into the D-cache, sharing its port with loads
module sb_drain_ctrl
  import sb_drain_ctrl_pkg::*;
#(
  parameter int NUM_LINES    = STOREBUFFER_NUM_LINES,
  parameter int IDX_W        = $clog2(NUM_LINES),
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] sb_valid,
  input  logic                 sb_full,
  input  logic                 load_req,
  input  logic                 fence,
  input  logic                 cache_ack,
  output logic                 cache_req,
  output logic [IDX_W-1:0]     drain_idx,
  output logic                 drain_pop,
  output logic                 load_grant,
  output logic                 sb_stall,
  output logic                 fence_done
);
  sbd_state_t       state, state_n;
  logic [CNT_W-1:0] starve_cnt, starve_n;
  logic [IDX_W-1:0] pick;
  logic             fence_pend, fence_pend_n, any, idle, force_drain, go, starved;
  sb_prio_enc #(.N(NUM_LINES), .W(IDX_W)) u_enc (
    .vec(sb_valid),
    .idx(pick),
    .any(any)
  );
  // Level outputs are gated by reset so nothing leaks out while it is held.
  always_comb begin
    idle         = state == SBD_IDLE;
    starved      = starve_cnt == CNT_W'(STARVE_LIMIT);
    force_drain  = (sb_full | fence_pend | starved) & any;
    go           = idle & (force_drain | (any & ~load_req));
    cache_req    = state == SBD_REQ;
    drain_pop    = state == SBD_POP;
    load_grant   = rst & idle & load_req & ~force_drain;
    fence_done   = rst & idle & fence_pend & ~any;
    sb_stall     = rst & (sb_full | fence_pend);
    state_n      = idle ? (go ? SBD_REQ : SBD_IDLE) : cache_req ? (cache_ack ? SBD_POP : SBD_REQ) : SBD_IDLE;
    starve_n     = (drain_pop | ~any) ? '0 : (load_grant & ~starved) ? starve_cnt + CNT_W'(1) : starve_cnt;
    fence_pend_n = (fence_pend | fence) & ~fence_done;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SBD_IDLE;
      starve_cnt <= '0;
      fence_pend <= 1'b0;
      drain_idx  <= '0;
    end else begin
      state      <= state_n;
      starve_cnt <= starve_n;
      fence_pend <= fence_pend_n;
      if (go) drain_idx <= pick;
    end
  end
endmodule

// File: tb/tb_sb_drain_ctrl.sv
// tb_sb_drain_ctrl: directed stimulus checked against a transaction-level drain/arbitration model
module tb_sb_drain_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] sb_valid = '0;
  logic       sb_full = 1'b0, load_req = 1'b0, fence = 1'b0, cache_ack = 1'b0;
  logic       cache_req, drain_pop, load_grant, sb_stall, fence_done;
  logic [1:0] drain_idx;
  int         errors = 0, checks = 0;

  sb_drain_ctrl dut (
    .clk(clk), .rst(rst), .sb_valid(sb_valid), .sb_full(sb_full), .load_req(load_req),
    .fence(fence), .cache_ack(cache_ack), .cache_req(cache_req), .drain_idx(drain_idx),
    .drain_pop(drain_pop), .load_grant(load_grant), .sb_stall(sb_stall), .fence_done(fence_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Model: which entry is being written (-1 = port free), whether its write was accepted,
  // how many loads have overtaken waiting stores, and whether a fence is outstanding.
  int m_cur = -1, m_last = 0, m_starve = 0, m_popped = -1;
  bit m_acked = 1'b0, m_fpend = 1'b0;
  logic e_free, e_forced, e_req, e_pop, e_grant, e_done, e_stall;
  assign e_free   = m_cur < 0;
  assign e_forced = (sb_full || m_fpend || m_starve >= 8) && sb_valid != 0;
  assign e_req    = rst && !e_free && !m_acked;
  assign e_pop    = rst && !e_free && m_acked;
  assign e_grant  = rst && e_free && load_req && !e_forced;
  assign e_done   = rst && e_free && m_fpend && sb_valid == 0;
  assign e_stall  = rst && (sb_full || m_fpend);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cur <= -1; m_acked <= 1'b0; m_starve <= 0; m_fpend <= 1'b0; m_last <= 0; m_popped <= -1;
    end else begin
      m_popped <= e_pop ? m_cur : -1;
      if (e_free && (e_forced || (sb_valid != 0 && !load_req))) begin
        m_cur  <= lowest(sb_valid);
        m_last <= lowest(sb_valid);
      end else if (e_req && cache_ack) m_acked <= 1'b1;
      else if (e_pop) begin
        m_cur   <= -1;
        m_acked <= 1'b0;
      end
      m_starve <= (sb_valid == 0 || e_pop) ? 0 : (e_grant && m_starve < 8) ? m_starve + 1 : m_starve;
      m_fpend  <= (m_fpend || fence) && !e_done;
    end
  end

  always @(negedge clk) begin
    chk("cache_req", int'(cache_req), int'(e_req));
    chk("drain_pop", int'(drain_pop), int'(e_pop));
    chk("load_grant", int'(load_grant), int'(e_grant));
    chk("fence_done", int'(fence_done), int'(e_done));
    chk("sb_stall", int'(sb_stall), int'(e_stall));
    chk("drain_idx", int'(drain_idx), m_last);
  end

  // The store buffer clears an entry on the edge that ends its pop cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (m_popped >= 0) sb_valid[m_popped] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n, order, last_pop, done_at, dones;
    bit seen;
    #1 rst = 1'b0;
    sb_full  = 1'b1;
    load_req = 1'b1;
    @(negedge clk);
    chk("rst_stall", int'(sb_stall), 0);
    chk("rst_grant", int'(load_grant), 0);
    sb_full  = 1'b0;
    load_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;

    // single entry, ack on the second request cycle
    sb_valid = 4'b0001;
    @(negedge clk) chk("t1_c0_req", int'(cache_req), 0);
    tick();
    @(negedge clk) chk("t1_c1_req", int'(cache_req), 1);
    chk("t1_c1_idx", int'(drain_idx), 0);
    tick();
    cache_ack = 1'b1;
    @(negedge clk) chk("t1_c2_req", int'(cache_req), 1);
    tick();
    cache_ack = 1'b0;
    @(negedge clk) chk("t1_c3_pop", int'(drain_pop), 1);
    chk("t1_c3_req", int'(cache_req), 0);
    tick();
    @(negedge clk) chk("t1_c4_pop", int'(drain_pop), 0);
    chk("t1_c4_req", int'(cache_req), 0);

    // starvation: loads hold the port for exactly eight cycles
    tick();
    sb_valid = 4'b0100;
    load_req = 1'b1;
    g = 0;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (cache_req) seen = 1'b1;
      else begin
        g += int'(load_grant);
        tick();
      end
    end
    chk("starve_req_seen", int'(seen), 1);
    chk("starve_grants", g, 8);
    chk("starve_idx", int'(drain_idx), 2);
    tick();
    cache_ack = 1'b1;
    for (int i = 0; i < 10 && sb_valid != 0; i++) tick();
    chk("starve_cleared", int'(sb_valid), 0);
    load_req = 1'b0;

    // full buffer: loads locked out, entries leave in index order
    sb_valid = 4'b1111;
    sb_full  = 1'b1;
    load_req = 1'b1;
    @(negedge clk) chk("full_stall", int'(sb_stall), 1);
    chk("full_grant0", int'(load_grant), 0);
    g = 0; n = 0; order = 0;
    for (int i = 0; i < 40 && sb_valid != 0; i++) begin
      @(negedge clk);
      g += int'(load_grant);
      if (drain_pop) begin
        order |= int'(drain_idx) << (2 * n);
        n++;
      end
      tick();
    end
    chk("full_pops", n, 4);
    chk("full_order", order, 'hE4);
    chk("full_grants", g, 0);
    sb_full  = 1'b0;

    // fence on two entries while loads keep asking
    sb_valid = 4'b0011;
    fence    = 1'b1;
    tick();
    fence = 1'b0;
    @(negedge clk) chk("fence_stall", int'(sb_stall), 1);
    n = 0; order = 0; last_pop = -1; done_at = -1; dones = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (drain_pop) begin
        order |= int'(drain_idx) << (2 * n);
        n++;
        last_pop = i;
      end
      if (fence_done) begin
        dones++;
        done_at = i;
      end
      tick();
    end
    chk("fence_pops", n, 2);
    chk("fence_order", order, 'h4);
    chk("fence_dones", dones, 1);
    chk("fence_done_lat", done_at - last_pop, 1);
    @(negedge clk) chk("fence_unstall", int'(sb_stall), 0);
    load_req = 1'b0;

    // fence on empty buffer
    tick();
    fence = 1'b1;
    @(negedge clk) chk("efence_c0", int'(fence_done), 0);
    tick();
    fence = 1'b0;
    @(negedge clk) chk("efence_c1", int'(fence_done), 1);
    tick();
    @(negedge clk) chk("efence_c2", int'(fence_done), 0);
    chk("efence_req", int'(cache_req), 0);

    // back-to-back fences yield a single completion
    fence = 1'b1;
    tick();
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) dones += int'(fence_done);
      tick();
      fence = 1'b0;
    end
    chk("dfence_dones", dones, 1);

    // async reset while a request waits for its ack
    cache_ack = 1'b0;
    sb_valid  = 4'b0001;
    tick();
    @(negedge clk) chk("areq_pre", int'(cache_req), 1);
    cache_ack = 1'b1;
    #2 rst = 1'b0;
    #1 chk("areq_drop", int'(cache_req), 0);
    sb_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) n += int'(drain_pop) + int'(cache_req);
      tick();
    end
    chk("areq_no_pop", n, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
